// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war controller: FSM states and winner codes.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN_HOLD   = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;

endpackage

// File: rtl/score_counter.sv
// One player's round-win counter: increments on en, sticks at MAX.
module score_counter #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] score
);

  logic [W-1:0] score_q;
  logic [W-1:0] score_d;

  // Next score: count up on enable unless already saturated.
  always_comb begin
    score_d = score_q;
    if (en && (score_q != W'(MAX))) begin
      score_d = score_q + W'(1);
    end
  end

  // Score register.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/tug_controller.sv
// Tug-of-war game controller: a light is pushed left/right by press pulses;
// pushing past an end wins the round, the win is shown for HOLD_CYCLES, and
// the match ends when a player reaches MAX_SCORE round wins.
module tug_controller #(
  parameter int NUM_POS     = 9,
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           l_press,
  input  logic                           r_press,
  output logic [NUM_POS-1:0]             leds,
  output logic [1:0]                     winner,
  output logic [$clog2(MAX_SCORE+1)-1:0] l_score,
  output logic [$clog2(MAX_SCORE+1)-1:0] r_score,
  output logic                           match_over
);
  import tug_pkg::*;

  localparam int PW = $clog2(NUM_POS);
  localparam int SW = $clog2(MAX_SCORE + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] CENTER = PW'((NUM_POS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_POS - 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [NUM_POS-1:0]   leds_q, leds_d;
  logic [1:0]           winner_q, winner_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 match_q, match_d;
  logic                 l_inc, r_inc;
  logic [SW-1:0]        l_score_w, r_score_w;

  // Next-state logic: moves, round wins, hold countdown and match end.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    winner_d = winner_q;
    hold_d   = hold_q;
    match_d  = match_q;
    l_inc    = 1'b0;
    r_inc    = 1'b0;
    case (state_q)
      PLAY: begin
        if (l_press && !r_press) begin
          if (pos_q == LAST) begin
            winner_d = LEFT;
            l_inc    = 1'b1;
            hold_d   = '0;
            state_d  = WIN_HOLD;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (r_press && !l_press) begin
          if (pos_q == '0) begin
            winner_d = RIGHT;
            r_inc    = 1'b1;
            hold_d   = '0;
            state_d  = WIN_HOLD;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end
      WIN_HOLD: begin
        // Scores were already bumped on entry, so they are final here.
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          hold_d = '0;
          if ((l_score_w == SW'(MAX_SCORE)) || (r_score_w == SW'(MAX_SCORE))) begin
            state_d = MATCH_OVER;
            match_d = 1'b1;
          end else begin
            state_d  = PLAY;
            pos_d    = CENTER;
            winner_d = NONE;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      MATCH_OVER: begin
        // Terminal: everything frozen until reset.
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // One-hot decode of the next position so leds comes straight from a flop.
  for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_led_decode
    assign leds_d[gi] = (pos_d == PW'(gi));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      pos_q    <= CENTER;
      leds_q   <= {{(NUM_POS-1){1'b0}}, 1'b1} << ((NUM_POS - 1) / 2);
      winner_q <= NONE;
      hold_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      leds_q   <= leds_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
      match_q  <= match_d;
    end
  end

  score_counter #(.MAX(MAX_SCORE), .W(SW)) u_l_score (
    .clk   (clk),
    .reset (reset),
    .en    (l_inc),
    .score (l_score_w)
  );

  score_counter #(.MAX(MAX_SCORE), .W(SW)) u_r_score (
    .clk   (clk),
    .reset (reset),
    .en    (r_inc),
    .score (r_score_w)
  );

  assign leds       = leds_q;
  assign winner     = winner_q;
  assign l_score    = l_score_w;
  assign r_score    = r_score_w;
  assign match_over = match_q;

endmodule

// File: tb/tb_tug_controller.sv
// Bench for tug_controller: directed press sequences with literal checks,
// plus an every-cycle comparison against an integer-position game model.
module tb_tug_controller;

  localparam int NP = 9;
  localparam int MS = 2;
  localparam int HC = 4;
  localparam int SW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          l_press = 1'b0;
  logic          r_press = 1'b0;
  logic [NP-1:0] leds;
  logic [1:0]    winner;
  logic [SW-1:0] l_score;
  logic [SW-1:0] r_score;
  logic          match_over;

  int checks = 0;
  int errors = 0;

  tug_controller #(.NUM_POS(NP), .MAX_SCORE(MS), .HOLD_CYCLES(HC)) dut (
    .clk        (clk),
    .reset      (reset),
    .l_press    (l_press),
    .r_press    (r_press),
    .leds       (leds),
    .winner     (winner),
    .l_score    (l_score),
    .r_score    (r_score),
    .match_over (match_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: light as a plain integer; pushing it past either end wins.
  int m_pos, m_l, m_r, m_win, m_hold_left;
  bit m_over;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int np;
    if (reset) begin
      m_pos = (NP - 1) / 2; m_l = 0; m_r = 0; m_win = 0;
      m_hold_left = 0; m_over = 1'b0; m_valid = 1'b1;
    end else if (m_valid && !m_over) begin
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          if (m_l == MS || m_r == MS) m_over = 1'b1;
          else begin m_pos = (NP - 1) / 2; m_win = 0; end
        end
      end else begin
        np = m_pos + ((l_press && !r_press) ? 1 : 0) - ((r_press && !l_press) ? 1 : 0);
        if (np > NP - 1) begin
          m_l = (m_l < MS) ? m_l + 1 : MS; m_win = 2; m_hold_left = HC;
        end else if (np < 0) begin
          m_r = (m_r < MS) ? m_r + 1 : MS; m_win = 1; m_hold_left = HC;
        end else m_pos = np;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, on the falling edge.
  always @(negedge clk) begin
    logic [NP-1:0] exp_leds;
    if (m_valid) begin
      exp_leds = '0;
      exp_leds[m_pos] = 1'b1;
      check("model_leds", 32'(leds), 32'(exp_leds));
      check("model_winner", 32'(winner), 32'(m_win));
      check("model_l_score", 32'(l_score), 32'(m_l));
      check("model_r_score", 32'(r_score), 32'(m_r));
      check("model_match_over", 32'(match_over), 32'(m_over));
    end
  end

  // Apply inputs for one edge; returns on the following falling edge.
  task automatic step(input logic l, input logic r);
    l_press = l;
    r_press = r;
    @(negedge clk);
    $display("step l=%0b r=%0b rst=%0b -> leds=%b winner=%b l=%0d r=%0d over=%0b",
             l, r, reset, leds, winner, l_score, r_score, match_over);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_leds"}, 32'(leds), 32'h010);
    check({tag, "_winner"}, 32'(winner), 32'h0);
    check({tag, "_l_score"}, 32'(l_score), 32'h0);
    check({tag, "_r_score"}, 32'(r_score), 32'h0);
    check({tag, "_match_over"}, 32'(match_over), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    reset = 1'b1;
    step(0, 0);
    step(0, 0);
    reset = 1'b0;
    check_reset_state("reset");

    // Three single right pulses walk the light 4 -> 3 -> 2 -> 1.
    step(0, 1); check("r1_leds", 32'(leds), 32'h008); step(0, 0);
    step(0, 1); check("r2_leds", 32'(leds), 32'h004); step(0, 0);
    step(0, 1); check("r3_leds", 32'(leds), 32'h002);
    check("r3_winner", 32'(winner), 32'h0);
    check("r3_scores", 32'({l_score, r_score}), 32'h0);

    // Back to centre, then a simultaneous press cancels.
    step(1, 0); step(1, 0); step(1, 0);
    check("back_centre", 32'(leds), 32'h010);
    step(1, 1);
    check("both_cancel_leds", 32'(leds), 32'h010);
    check("both_cancel_scores", 32'({l_score, r_score}), 32'h0);

    // Held left press: one move per cycle.
    step(1, 0); step(1, 0); step(1, 0);
    check("held_l_leds", 32'(leds), 32'h080);
    step(0, 1); step(0, 1); step(0, 1);

    // Five left presses from centre: fifth one wins the round.
    for (int i = 0; i < 4; i++) step(1, 0);
    check("left_end_leds", 32'(leds), 32'h100);
    check("left_end_winner", 32'(winner), 32'h0);
    step(1, 0);
    check("lwin_winner", 32'(winner), 32'h2);
    check("lwin_l_score", 32'(l_score), 32'h1);
    check("lwin_leds", 32'(leds), 32'h100);
    // Presses during the hold are ignored; round restarts after 4 cycles.
    step(1, 0); step(0, 1); step(1, 1);
    check("hold3_winner", 32'(winner), 32'h2);
    check("hold3_leds", 32'(leds), 32'h100);
    step(0, 1);
    check("after_hold_leds", 32'(leds), 32'h010);
    check("after_hold_winner", 32'(winner), 32'h0);
    check("after_hold_l_score", 32'(l_score), 32'h1);

    // Two right wins reach MAX_SCORE=2 and end the match.
    for (int i = 0; i < 5; i++) step(0, 1);
    check("rwin1_r_score", 32'(r_score), 32'h1);
    check("rwin1_winner", 32'(winner), 32'h1);
    check("rwin1_leds", 32'(leds), 32'h001);
    for (int i = 0; i < 4; i++) step(0, 0);
    check("rwin1_resume", 32'(leds), 32'h010);
    for (int i = 0; i < 5; i++) step(0, 1);
    check("rwin2_r_score", 32'(r_score), 32'h2);
    check("rwin2_match_not_yet", 32'(match_over), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0);
    check("match_over", 32'(match_over), 32'h1);
    check("match_leds", 32'(leds), 32'h001);
    check("match_winner", 32'(winner), 32'h1);
    step(1, 0); step(0, 1); step(1, 0); step(1, 1);
    check("frozen_leds", 32'(leds), 32'h001);
    check("frozen_scores", 32'({l_score, r_score}), 32'h6);
    check("frozen_match_over", 32'(match_over), 32'h1);

    // Reset out of MATCH_OVER.
    reset = 1'b1; step(1, 0); reset = 1'b0;
    check_reset_state("rst_match");

    // Reset on the second hold cycle.
    for (int i = 0; i < 5; i++) step(1, 0);
    check("win_before_rst", 32'(winner), 32'h2);
    step(0, 0);
    reset = 1'b1; step(1, 0); reset = 1'b0;
    check_reset_state("rst_hold");
    step(1, 0);
    check("play_after_rst", 32'(leds), 32'h020);
    step(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
